// File: rtl/aes_pkg.sv
// Shared types and constants for the AES ciphertext collector.
package aes_pkg;
  localparam int BLK_BYTES  = 16;
  localparam int BLOCK_W    = 128;
  localparam int BYTE_CNT_W = $clog2(BLK_BYTES);

  typedef logic [7:0]         aes_byte_t;
  typedef logic [BLOCK_W-1:0] aes_block_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPT,
    ST_DRAIN
  } cap_state_t;
endpackage

// File: rtl/aes_cipher_collector_if.sv
// Block-level valid/ready link from the collector to its consumer.
interface aes_cipher_collector_if;
  import aes_pkg::*;

  aes_block_t data;
  logic       valid;
  logic       ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/aes_blk_fifo.sv
// Small block FIFO with a registered head word; one extra pointer bit tells full from empty.
module aes_blk_fifo
  import aes_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  aes_block_t push_data,
  input  logic       pop,
  output aes_block_t head,
  output logic       valid,
  output logic       full
);
  localparam int AW = $clog2(DEPTH);

  aes_block_t    mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [AW:0]   wr_nxt, rd_nxt;
  logic          empty, do_pop, do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign valid   = !empty;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign wr_nxt  = do_push ? wr_ptr + (AW+1)'(1) : wr_ptr;
  assign rd_nxt  = do_pop  ? rd_ptr + (AW+1)'(1) : rd_ptr;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // The head slot may be the one being written this cycle, so bypass the incoming word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      head   <= '0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      if (wr_nxt != rd_nxt) begin
        if (do_push && (wr_ptr[AW-1:0] == rd_nxt[AW-1:0])) head <= push_data;
        else                                               head <= mem[rd_nxt[AW-1:0]];
      end
    end
  end
endmodule

// File: rtl/aes_cipher_collector.sv
// Reassembles byte-serial AES ciphertext bursts into 128-bit blocks and queues them for a consumer.
//   state    | meaning
//   ST_IDLE  | waiting for burst header (aes_ready rise)
//   ST_CAPT  | shifting in data bytes 0..15
//   ST_DRAIN | block pushed, waiting for aes_ready to fall
module aes_cipher_collector
  import aes_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   aes_ready,
  input  aes_byte_t              aes_byte,
  aes_cipher_collector_if.master out_bus,
  output logic [CNT_W-1:0]       blk_count,
  output logic                   err_short,
  output logic                   err_overflow,
  input  logic                   clr_err
);
  localparam logic [BYTE_CNT_W-1:0] LAST = BYTE_CNT_W'(BLK_BYTES - 1);

  cap_state_t              state;
  logic [BYTE_CNT_W-1:0]   cnt;
  logic [BLOCK_W-9:0]      shreg;
  logic                    push, short_evt, accept, drop, fifo_full;

  assign push      = (state == ST_CAPT) && aes_ready && (cnt == LAST);
  assign short_evt = (state == ST_CAPT) && !aes_ready;
  // A full FIFO is never empty, so ready alone guarantees a pop frees a slot.
  assign accept    = push && (!fifo_full || out_bus.ready);
  assign drop      = push && fifo_full && !out_bus.ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      shreg        <= '0;
      blk_count    <= '0;
      err_short    <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (aes_ready) begin
            state <= ST_CAPT;
            cnt   <= '0;
          end
        end
        ST_CAPT: begin
          if (aes_ready) begin
            shreg <= {shreg[BLOCK_W-17:0], aes_byte};
            cnt   <= cnt + BYTE_CNT_W'(1);
            if (cnt == LAST) state <= ST_DRAIN;
          end else begin
            state <= ST_IDLE;
            cnt   <= '0;
          end
        end
        ST_DRAIN: begin
          if (!aes_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      if (accept) blk_count <= blk_count + CNT_W'(1);

      if (short_evt)    err_short <= 1'b1;
      else if (clr_err) err_short <= 1'b0;

      if (drop)         err_overflow <= 1'b1;
      else if (clr_err) err_overflow <= 1'b0;
    end
  end

  aes_blk_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({shreg, aes_byte}),
    .pop       (out_bus.ready),
    .head      (out_bus.data),
    .valid     (out_bus.valid),
    .full      (fifo_full)
  );
endmodule

// File: tb/tb_aes_cipher_collector.sv
// Directed and randomized bursts checked against a queue-based block model.
module tb_aes_cipher_collector;
  import aes_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        aes_ready = 1'b0;
  logic [7:0]  aes_byte = 8'h00;
  logic        out_ready = 1'b0;
  logic        clr_err = 1'b0;
  logic [15:0] blk_count;
  logic        err_short, err_overflow;

  aes_cipher_collector_if ob ();
  assign ob.ready = out_ready;

  aes_cipher_collector #(.DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .aes_ready    (aes_ready),
    .aes_byte     (aes_byte),
    .out_bus      (ob),
    .blk_count    (blk_count),
    .err_short    (err_short),
    .err_overflow (err_overflow),
    .clr_err      (clr_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [127:0] q[$];
  logic [15:0]  m_cnt = '0;
  logic         m_short = 1'b0;
  logic         m_ovf = 1'b0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("out_valid", ob.valid, q.size() != 0);
    if (q.size() != 0) chk("out_data", ob.data, q[0]);
    chk("blk_count", blk_count, m_cnt);
    chk("err_short", err_short, m_short);
    chk("err_overflow", err_overflow, m_ovf);
  endtask

  // One clock: apply inputs, advance the model at the edge, compare shortly after.
  task automatic step(input logic rdy, input logic [7:0] b, input logic push_evt,
                      input logic [127:0] blk, input logic short_evt);
    logic ovf_set;
    aes_ready = rdy;
    aes_byte  = b;
    @(posedge clk);
    ovf_set = 1'b0;
    if (out_ready && q.size() > 0) void'(q.pop_front());
    if (push_evt) begin
      if (q.size() < DEPTH) begin
        q.push_back(blk);
        m_cnt++;
      end else ovf_set = 1'b1;
    end
    if (short_evt)    m_short = 1'b1;
    else if (clr_err) m_short = 1'b0;
    if (ovf_set)      m_ovf = 1'b1;
    else if (clr_err) m_ovf = 1'b0;
    #1;
    check_all();
  endtask

  task automatic idle();
    step(1'b0, 8'($urandom), 1'b0, '0, 1'b0);
  endtask

  // base < 0 gives random bytes; nbytes < 16 is a truncated burst.
  task automatic burst(input int nbytes, input int base, input int extra,
                       input bit clr_end, input bit pop_last);
    logic [127:0] blk;
    logic [7:0]   b;
    logic         saved;
    blk = '0;
    step(1'b1, 8'($urandom), 1'b0, '0, 1'b0);
    for (int i = 0; i < nbytes; i++) begin
      b   = (base < 0) ? 8'($urandom) : 8'(base + i);
      blk = {blk[119:0], b};
      saved = out_ready;
      if (i == 15 && pop_last) out_ready = 1'b1;
      step(1'b1, b, i == 15, blk, 1'b0);
      out_ready = saved;
    end
    if (nbytes >= 16) begin
      for (int k = 0; k < extra; k++) step(1'b1, 8'($urandom), 1'b0, '0, 1'b0);
      step(1'b0, 8'($urandom), 1'b0, '0, 1'b0);
    end else begin
      clr_err = clr_end;
      step(1'b0, 8'($urandom), 1'b0, '0, 1'b1);
      clr_err = 1'b0;
    end
  endtask

  initial begin
    #3;
    chk("rst_valid", ob.valid, 0);
    chk("rst_data", ob.data, 0);
    chk("rst_count", blk_count, 0);
    chk("rst_short", err_short, 0);
    chk("rst_ovf", err_overflow, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // single burst 00..0F with consumer ready
    out_ready = 1'b1;
    burst(16, 'h00, 0, 0, 0);
    idle();

    // three bursts, consumer stalled: third is dropped
    out_ready = 1'b0;
    repeat (3) burst(16, -1, 0, 0, 0);
    chk("t2_ovf", err_overflow, 1);
    out_ready = 1'b1;
    repeat (3) idle();

    clr_err = 1'b1; idle(); clr_err = 1'b0;
    chk("t6_clr_ovf", err_overflow, 0);

    // truncated burst then a clean A0..AF burst
    burst(7, 'h10, 0, 0, 0);
    chk("t3_short", err_short, 1);
    burst(16, 'hA0, 0, 0, 0);
    idle();

    // clear coinciding with a short-burst event: set wins
    clr_err = 1'b1; idle(); clr_err = 1'b0;
    burst(5, -1, 0, 1, 0);
    chk("t6_set_wins", err_short, 1);

    // full FIFO, pop coincides with byte 15 of the next burst
    out_ready = 1'b0;
    repeat (2) burst(16, -1, 0, 0, 0);
    burst(16, -1, 0, 0, 1);
    chk("t4_no_ovf", err_overflow, 0);
    out_ready = 1'b1;
    repeat (3) idle();

    // extra high cycles after byte 15 are ignored
    burst(16, -1, 3, 0, 0);
    idle();

    // async reset during byte 9 of a burst
    out_ready = 1'b0;
    burst(16, -1, 0, 0, 0);
    step(1'b1, 8'($urandom), 1'b0, '0, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b1, 8'($urandom), 1'b0, '0, 1'b0);
    aes_ready = 1'b1;
    aes_byte  = 8'h99;
    #2;
    rst = 1'b0;
    #1;
    chk("t5_valid", ob.valid, 0);
    chk("t5_data", ob.data, 0);
    chk("t5_count", blk_count, 0);
    chk("t5_short", err_short, 0);
    chk("t5_ovf", err_overflow, 0);
    q.delete();
    m_cnt = '0; m_short = 1'b0; m_ovf = 1'b0;
    aes_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    out_ready = 1'b1;
    burst(16, -1, 0, 0, 0);
    idle();

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      int len;
      out_ready = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : 16;
      burst(len, -1, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        out_ready = 1'($urandom_range(0, 1));
        clr_err   = ($urandom_range(0, 7) == 0);
        idle();
        clr_err = 1'b0;
      end
    end
    out_ready = 1'b1;
    repeat (3) idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
